// File: rtl/ram_bist.sv
// ram_bist: four-phase march self-test engine for a single-port RAM.
// The phases are write pattern, read/compare, write inverse, and read/compare descending.
// Expected data is E(a) = PATTERN ^ a. The inverse phases use ~E(a).
// Optional feature macro: RAM_BIST_STOP_ON_FAIL_EN. When it is defined, the first
// mismatch ends the test on the next cycle.
module ram_bist #(
  parameter int                 ADDR_W  = 4,
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  PATTERN = DATA_W'(8'hA5)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ram_en,
  output logic                ram_wr_rd,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W+1:0]   err_cnt,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data
);

  localparam int                CNT_W    = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, WR_PAT, RD_PAT, WR_INV, RD_INV, DONE
  } state_t;

  state_t              state, state_nxt;
  logic                en_nxt, wr_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   din_nxt;
  logic                clear;
  logic                issue;
  logic                mismatch;
  logic                first_seen;
  logic [CNT_W-1:0]    err_nxt;

  // Compare stage registers: expected data and address of the read issued last cycle
  logic                vld_p1;
  logic [DATA_W-1:0]   exp_p1;
  logic [ADDR_W-1:0]   addr_p1;

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    return PATTERN ^ DATA_W'(a);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign issue    = ((state == RD_PAT) || (state == RD_INV)) && ram_en;
  assign mismatch = vld_p1 && (ram_dout != exp_p1);
  assign err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;

  // Next-state and next registered RAM-side outputs; the address register doubles as the phase counter
  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = ram_addr;
    din_nxt   = ram_din;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WR_PAT;
          en_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = '0;
          din_nxt   = exp_data('0);
          busy_nxt  = 1'b1;
          pass_nxt  = 1'b0;
          clear     = 1'b1;
        end
      end
      WR_PAT: begin
        en_nxt = 1'b1;
        if (ram_addr == ADDR_MAX) begin
          state_nxt = RD_PAT;
          addr_nxt  = '0;
        end else begin
          wr_nxt   = 1'b1;
          addr_nxt = ram_addr + ADDR_W'(1);
          din_nxt  = exp_data(ram_addr + ADDR_W'(1));
        end
      end
      RD_PAT: begin
        if (ram_en) begin
          // Last ascending read wraps the address back to 0 and opens the drain cycle
          en_nxt   = (ram_addr != ADDR_MAX);
          addr_nxt = ram_addr + ADDR_W'(1);
        end else begin
          state_nxt = WR_INV;
          en_nxt    = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = '0;
          din_nxt   = ~exp_data('0);
        end
      end
      WR_INV: begin
        en_nxt = 1'b1;
        if (ram_addr == ADDR_MAX) begin
          state_nxt = RD_INV;
          addr_nxt  = ADDR_MAX;
        end else begin
          wr_nxt   = 1'b1;
          addr_nxt = ram_addr + ADDR_W'(1);
          din_nxt  = ~exp_data(ram_addr + ADDR_W'(1));
        end
      end
      RD_INV: begin
        if (ram_en) begin
          en_nxt   = (ram_addr != '0);
          addr_nxt = ram_addr - ADDR_W'(1);
        end else begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_nxt = DONE;
      en_nxt    = 1'b0;
      wr_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      pass_nxt  = 1'b0;
    end
`endif
  end

  // State and registered outputs; reset drops the RAM enable immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ram_en    <= en_nxt;
      ram_wr_rd <= wr_nxt;
      ram_addr  <= addr_nxt;
      ram_din   <= din_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      vld_p1    <= issue && (state_nxt != DONE);
    end
  end

  // Expected data for the read being issued; it lines up with ram_dout one cycle later
  always_ff @(posedge clk) begin
    exp_p1  <= (state == RD_INV) ? ~exp_data(ram_addr) : exp_data(ram_addr);
    addr_p1 <= ram_addr;
  end

  // Mismatch bookkeeping: saturating count, and the first failure latched once per test
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      first_seen <= 1'b0;
    end else if (clear) begin
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      first_seen <= 1'b0;
    end else if (mismatch) begin
      err_cnt <= err_nxt;
      if (!first_seen) begin
        first_seen <= 1'b1;
        fail_addr  <= addr_p1;
        fail_data  <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed bench for ram_bist, using a behavioural RAM with injectable faults.
// Fault modes: 0 = good, 1 = bit 0 stuck at 0 at address 3, 2 = address bit 3 ignored.
module tb_ram_bist;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              ram_en, ram_wr_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic              busy, done, pass;
  logic [ADDR_W+1:0] err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  int vectors = 0;
  int miscompares = 0;
  int fault_mode = 0;

  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W-1:0] ra;

  ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency
  assign ra = (fault_mode == 2) ? {1'b0, ram_addr[2:0]} : ram_addr;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr_rd) mem[ra] <= ram_din;
      else if (fault_mode == 1 && ra == 4'd3) ram_dout <= mem[ra] & 8'hFE;
      else ram_dout <= mem[ra];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, capture the first presented access, count busy cycles (bounded)
  task automatic do_run(input int pulse_at, output int nbusy,
                        output logic [1+1+ADDR_W+DATA_W-1:0] first);
    start = 1'b1;
    step();
    start = 1'b0;
    first = {ram_en, ram_wr_rd, ram_addr, ram_din};
    nbusy = 0;
    while (busy && nbusy < 200) begin
      nbusy++;
      start = (nbusy == pulse_at);
      step();
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (5) step();
    vectors++;
    if ({ram_en, ram_wr_rd, ram_addr, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram_side: got %h want 0", {ram_en, ram_wr_rd, ram_addr, ram_din});
    end
    vectors++;
    if ({busy, done, pass, err_cnt, fail_addr, fail_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 0", {busy, done, pass, err_cnt, fail_addr, fail_data});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_good(input int pulse_at, input string tag);
    int nbusy;
    logic [1+1+ADDR_W+DATA_W-1:0] first;
    fault_mode = 0;
    do_run(pulse_at, nbusy, first);
    vectors++;
    if (first !== {1'b1, 1'b1, 4'd0, 8'hA5}) begin
      miscompares++;
      $display("FAIL %s first_write: got %h want %h", tag, first, {1'b1, 1'b1, 4'd0, 8'hA5});
    end
    vectors++;
    if (nbusy !== 66) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want 66", tag, nbusy);
    end
    vectors++;
    if ({done, busy, pass, ram_en} !== 4'b1010) begin
      miscompares++;
      $display("FAIL %s done_pass: got done/busy/pass/en=%b want 1010", tag, {done, busy, pass, ram_en});
    end
    vectors++;
    if (err_cnt !== '0) begin
      miscompares++;
      $display("FAIL %s err_cnt: got %0d want 0", tag, err_cnt);
    end
    // start on the done cycle must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({done, busy, pass} !== 3'b001) begin
      miscompares++;
      $display("FAIL %s start_on_done: got done/busy/pass=%b want 001", tag, {done, busy, pass});
    end
    step();
  endtask

  task automatic test_stuck_at();
    int nbusy;
    logic [1+1+ADDR_W+DATA_W-1:0] first;
    fault_mode = 1;
    do_run(-1, nbusy, first);
    vectors++;
    if (nbusy !== (STOP ? 63 : 66)) begin
      miscompares++;
      $display("FAIL stuck busy_cycles: got %0d want %0d", nbusy, STOP ? 63 : 66);
    end
    vectors++;
    if ({done, busy, pass, ram_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL stuck done_pass: got done/busy/pass/en=%b want 1000", {done, busy, pass, ram_en});
    end
    vectors++;
    if ({err_cnt, fail_addr, fail_data} !== {6'd1, 4'd3, 8'h58}) begin
      miscompares++;
      $display("FAIL stuck err_fail: got cnt=%0d addr=%0d data=%h want 1 3 58", err_cnt, fail_addr, fail_data);
    end
    step();
    vectors++;
    if ({ram_en, done, pass} !== 3'b000) begin
      miscompares++;
      $display("FAIL stuck after_done: got en/done/pass=%b want 000", {ram_en, done, pass});
    end
    step();
  endtask

  task automatic test_alias();
    int nbusy;
    logic [1+1+ADDR_W+DATA_W-1:0] first;
    fault_mode = 2;
    do_run(-1, nbusy, first);
    vectors++;
    if (nbusy !== (STOP ? 18 : 66)) begin
      miscompares++;
      $display("FAIL alias busy_cycles: got %0d want %0d", nbusy, STOP ? 18 : 66);
    end
    vectors++;
    if ({done, pass, ram_en} !== 3'b100) begin
      miscompares++;
      $display("FAIL alias done_pass: got done/pass/en=%b want 100", {done, pass, ram_en});
    end
    vectors++;
    if (err_cnt !== (STOP ? 6'd1 : 6'd16)) begin
      miscompares++;
      $display("FAIL alias err_cnt: got %0d want %0d", err_cnt, STOP ? 1 : 16);
    end
    vectors++;
    if ({fail_addr, fail_data} !== {4'd0, 8'hAD}) begin
      miscompares++;
      $display("FAIL alias first_fail: got addr=%0d data=%h want 0 ad", fail_addr, fail_data);
    end
    step();
    step();
    fault_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    fault_mode = 0;
    saw_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) begin
      saw_done |= done;
      step();
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({ram_en, ram_wr_rd, ram_addr, ram_din, busy, done, err_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got en=%b busy=%b addr=%0d din=%h want all 0", ram_en, busy, ram_addr, ram_din);
    end
    repeat (3) begin
      step();
      saw_done |= done;
    end
    rst = 1'b1;
    repeat (3) begin
      step();
      saw_done |= done | busy;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid no_done: got done_or_busy_seen=%b want 0", saw_done);
    end
  endtask

  initial begin
    test_reset();
    test_good(-1, "good");
    test_stuck_at();
    test_alias();
    test_good(10, "start_in_busy");
    test_reset_mid();
    test_good(-1, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
